// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and FIPS 180-4 bit functions for sha256_folded.
package sha256_pkg;

  typedef enum logic [2:0] {IDLE, RUN, FINAL, PASS2, DONE} state_e;

  typedef struct packed {
    logic [31:0] a, b, c, d, e, f, g, h;
  } work_t;

  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bigSigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bigSigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] smallSigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] smallSigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round on the a..h working state.
module sha256_round
  import sha256_pkg::*;
(
  input  work_t       i_state,
  input  logic [31:0] i_k,
  input  logic [31:0] i_w,
  output work_t       o_state
);

  logic [31:0] w_t1, w_t2;

  assign w_t1 = i_state.h + bigSigma1(i_state.e) + ch(i_state.e, i_state.f, i_state.g) + i_k + i_w;
  assign w_t2 = bigSigma0(i_state.a) + maj(i_state.a, i_state.b, i_state.c);

  assign o_state = '{a: w_t1 + w_t2, b: i_state.a, c: i_state.b, d: i_state.c,
                     e: i_state.d + w_t1, f: i_state.e, g: i_state.f, h: i_state.g};

endmodule

// File: rtl/sha256_folded.sv
// Folded SHA-256 block compressor doing UNROLL rounds per clock.
// Define SHA256_FOLDED_DOUBLE_EN to build the optional second (double SHA-256) pass.
module sha256_folded
  import sha256_pkg::*;
#(
  parameter int UNROLL = 4
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] init,
  input  logic [511:0] chunk,
  input  logic         double_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] hash,
  output logic         busy
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_badUnroll
    $error("sha256_folded: UNROLL must be 1, 2, 4, 8 or 16");
  end

  state_e       r_state;
  logic [6:0]   r_cnt;
  logic         r_inReady, r_outValid, r_busy;
  logic [255:0] r_hash;
  logic [255:0] r_st, r_chain;
  logic [31:0]  r_w [16];
  logic [31:0]  w_ext [16+UNROLL];
  logic [255:0] w_digest;
  work_t        w_roundOut;

`ifdef SHA256_FOLDED_DOUBLE_EN
  logic r_double, r_pass;
`else
  logic w_unusedDouble;
  assign w_unusedDouble = double_i;
`endif

  // Round chain: each stage feeds the next within the same cycle.
  for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
    work_t w_in, w_out;
    if (j == 0) begin : g_head
      assign w_in = work_t'(r_st);
    end else begin : g_tail
      assign w_in = g_rnd[j-1].w_out;
    end
    sha256_round u_round (
      .i_state(w_in),
      .i_k    (K[r_cnt[5:0] + 6'(j)]),
      .i_w    (r_w[j]),
      .o_state(w_out)
    );
  end
  assign w_roundOut = g_rnd[UNROLL-1].w_out;

  always_comb begin
    for (int i = 0; i < 16; i++) w_ext[i] = r_w[i];
    for (int i = 16; i < 16 + UNROLL; i++)
      w_ext[i] = smallSigma1(w_ext[i-2]) + w_ext[i-7] + smallSigma0(w_ext[i-15]) + w_ext[i-16];
  end

  always_comb begin
    w_digest = '0;
    for (int i = 0; i < 8; i++) w_digest[i*32 +: 32] = r_chain[i*32 +: 32] + r_st[i*32 +: 32];
  end

  // Datapath registers carry no reset; their contents only matter once a job is running.
  always_ff @(posedge clk) begin
    case (r_state)
      IDLE: if (in_valid) begin
        r_st    <= init;
        r_chain <= init;
        for (int i = 0; i < 16; i++) r_w[i] <= chunk[511-32*i -: 32];
      end
      RUN: begin
        r_st <= w_roundOut;
        for (int i = 0; i < 16; i++) r_w[i] <= w_ext[i+UNROLL];
      end
`ifdef SHA256_FOLDED_DOUBLE_EN
      PASS2: begin
        r_st    <= IV;
        r_chain <= IV;
        for (int i = 0; i < 8; i++) r_w[i] <= r_hash[255-32*i -: 32];
        r_w[8] <= 32'h80000000;
        for (int i = 9; i < 15; i++) r_w[i] <= 32'h0;
        r_w[15] <= 32'h00000100;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
      r_hash     <= '0;
`ifdef SHA256_FOLDED_DOUBLE_EN
      r_double   <= 1'b0;
      r_pass     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_cnt     <= '0;
          r_inReady <= 1'b0;
          r_busy    <= 1'b1;
          r_state   <= RUN;
`ifdef SHA256_FOLDED_DOUBLE_EN
          r_double  <= double_i;
          r_pass    <= 1'b0;
`endif
        end
        RUN: begin
          r_cnt <= r_cnt + 7'(UNROLL);
          if (r_cnt + 7'(UNROLL) == 7'd64) r_state <= FINAL;
        end
        FINAL: begin
          r_hash <= w_digest;
`ifdef SHA256_FOLDED_DOUBLE_EN
          if (r_double && !r_pass) begin
            r_state <= PASS2;
          end else begin
            r_state    <= DONE;
            r_outValid <= 1'b1;
          end
`else
          r_state    <= DONE;
          r_outValid <= 1'b1;
`endif
        end
`ifdef SHA256_FOLDED_DOUBLE_EN
        PASS2: begin
          r_pass  <= 1'b1;
          r_cnt   <= '0;
          r_state <= RUN;
        end
`endif
        DONE: if (out_ready) begin
          r_outValid <= 1'b0;
          r_inReady  <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign busy      = r_busy;
  assign hash      = r_hash;

endmodule

// File: doc/sha256_folded.md
SHA256_FOLDED -- requirements
Module: sha256_folded

Interface
- REQ-001: Parameter `UNROLL`, default 4: number of compression rounds evaluated per clock. Legal values are 1, 2, 4, 8 and 16.
- REQ-002: `clk`, input, 1 bit: clock; all state updates on the rising edge.
- REQ-003: `arst`, input, 1 bit: reset; asynchronous, active-high.
- REQ-004: `in_valid`, input, 1 bit: a job is offered on `init`/`chunk`/`double_i`.
- REQ-005: `in_ready`, output, 1 bit: the core can accept a job.
- REQ-006: `init`, input, 256 bits: chaining value; word 0 at [255:224].
- REQ-007: `chunk`, input, 512 bits: message block; word 0 at [511:480].
- REQ-008: `double_i`, input, 1 bit: request a double SHA-256 (second pass).
- REQ-009: `out_valid`, output, 1 bit: `hash` holds a result.
- REQ-010: `out_ready`, input, 1 bit: downstream accepts the result.
- REQ-011: `hash`, output, 256 bits: result; word 0 at [255:224].
- REQ-012: `busy`, output, 1 bit: high in any state other than IDLE.

Function
- REQ-013: FSM states are IDLE, RUN, FINAL, PASS2, DONE; `in_ready` is high only in IDLE.
- REQ-014: In IDLE, when `in_valid` and `in_ready` are both high at a rising edge:
  - `init`, `chunk` and `double_i` are captured;
  - round counter cleared to 0;
  - a..h loaded from `init`;
  - go to RUN.
- REQ-015: Each cycle in RUN:
  - performs `UNROLL` consecutive rounds using K[r..r+UNROLL-1] and schedule words W[r..r+UNROLL-1];
  - advances the 16-word schedule window by `UNROLL` words;
  - increments the round counter by `UNROLL`.
- REQ-016: When the counter reaches 64, RUN goes to FINAL. FINAL adds the pass's chaining value word-wise, modulo 2^32, to a..h.
- REQ-017: From FINAL:
  - if the double flag is set and pass 1 is complete, go to PASS2;
  - otherwise go to DONE with `out_valid` high.
- REQ-018: PASS2 takes one cycle, then enters RUN for pass 2:
  - new block = pass-1 digest words 0–7, word 8 = 0x80000000, words 9–14 = 0, word 15 = 0x00000100;
  - chaining value = standard SHA-256 IV.
- REQ-019: Latency from the input handshake edge to `out_valid` high is 64/`UNROLL`+1 cycles for a single pass and 2×(64/`UNROLL`+1)+1 cycles for a double pass.
- REQ-020: In DONE, `hash` and `out_valid` are held stable until `out_ready` is high at a rising edge; then go to IDLE.
- REQ-021: `in_valid` is ignored while not in IDLE; no job is queued or dropped silently, because `in_ready` is low.
- REQ-022: `out_ready` high outside DONE has no effect.
- REQ-023: All additions are 32-bit, modulo 2^32; rotations follow FIPS 180-4.

Reset
- REQ-024: When `arst` is asserted, the core enters IDLE immediately:
  - `in_ready` = 1;
  - `out_valid` = 0;
  - `busy` = 0;
  - `hash` = 0;
  - round counter, pass flag and double flag = 0.
- REQ-025: Assertion of `arst` during RUN, FINAL, PASS2 or DONE abandons the job; no `out_valid` is produced for it after release.
- REQ-026: The datapath registers (a..h, schedule) need not be reset.

Configuration
- REQ-027: Macro `SHA256_FOLDED_DOUBLE_EN`:
  - defined: PASS2 and the double-pass behaviour are built;
  - undefined: `double_i` is ignored (treated as 0), the PASS2 logic is absent, and every job is a single pass.

Structure
- REQ-028: Package `sha256_pkg` holds:
  - the K[0..63] table;
  - the IV constant;
  - the FSM state typedef;
  - the rotate, Σ0, Σ1, σ0, σ1, Ch and Maj functions.
- REQ-029: Sub-module `sha256_round` is one combinational compression round. It is instantiated `UNROLL` times, chained within `sha256_folded`.
- REQ-030: An elaboration-time check rejects an illegal `UNROLL`.

Verification
- REQ-031: Input `init` = IV, `chunk` = "abc" padded (0x61626380, zeros, word 15 = 0x00000018), `double_i` = 0, `UNROLL` = 4:
  - `hash` = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad;
  - `out_valid` high 17 cycles after the handshake.
- REQ-032: Input `chunk` = 0x80000000 followed by zeros, `init` = IV:
  - `hash` = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855;
  - this holds for every legal `UNROLL` (1, 2, 4, 8, 16).
- REQ-033: With `SHA256_FOLDED_DOUBLE_EN` defined, the "abc" block with `double_i` = 1:
  - `hash` = 4f8b42c2 2dd3729b 519ba6f6 8d2da7cc 5b2d606d 05daed5a d5128cc0 3e6c6358;
  - `out_valid` at 35 cycles (`UNROLL` = 4).
- REQ-034: Backpressure: `out_ready` held low for 10 cycles in DONE:
  - `hash` stable;
  - `in_ready` stays 0;
  - a second `in_valid` is not accepted until the cycle after the output handshake.
- REQ-035: `arst` pulsed in the middle of RUN:
  - outputs take their reset values immediately;
  - no `out_valid` for the abandoned job;
  - the next "abc" job produces the correct digest.
